huffman_dec: RTL and testbench

- Serial Huffman decoder. It is the receive end of the existing Huffman encoder's serial out_code stream.
- A per-character code table is loaded for the 8-letter alphabet A,B,C,E,I,L,O,V. The block then consumes a serial bitstream, one bit per cycle, and emits one 3-bit character index per completed codeword.
- Used as the loop-back checker for the encoder, and as the decode stage in the compression datapath.

---
 rtl/huffman_dec_if.sv | 23 ++
 rtl/huffman_dec.sv | 178 +++++++++++++++++
 tb/tb_huffman_dec.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_dec_if.sv
// Bus bundle between the table/bit source and the serial Huffman decoder.
interface huffman_dec_if;
    logic       in_valid;
    logic [2:0] in_len;
    logic [6:0] in_code;
    logic       bit_valid;
    logic       bit_in;
    logic       bit_last;
    logic       out_valid;
    logic [2:0] out_char;
    logic       out_done;
    logic       out_err;

    modport master (
        output in_valid, in_len, in_code, bit_valid, bit_in, bit_last,
        input  out_valid, out_char, out_done, out_err
    );

    modport slave (
        input  in_valid, in_len, in_code, bit_valid, bit_in, bit_last,
        output out_valid, out_char, out_done, out_err
    );
endinterface

// File: rtl/huffman_dec.sv
// Serial Huffman decoder: loads an 8-entry code table, then consumes one
// code bit per cycle and emits the symbol index one cycle after the bit
// that completes a codeword.
module huffman_dec #(
    parameter int SYM_NUM = 8,
    parameter int MAX_LEN = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    huffman_dec_if.slave bus
);
    localparam int IDX_W = $clog2(SYM_NUM);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {IDLE, LOAD, READY, DECODE, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    state_t             after_bit;

    logic [LEN_W-1:0]   tbl_len  [SYM_NUM];
    logic [MAX_LEN-1:0] tbl_code [SYM_NUM];
    logic [IDX_W-1:0]   load_idx;
    logic [MAX_LEN-1:0] acc;
    logic [LEN_W-1:0]   cnt;

    logic [MAX_LEN-1:0] acc_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   cnt_nxt;
    logic               match_hit;
    logic [IDX_W-1:0]   match_idx;
    logic               take_bit;
    logic               overflow;
    logic               word_end;

    logic               out_valid_d;
    logic [IDX_W-1:0]   out_char_d;
    logic               out_done_d;
    logic               out_err_d;
    logic               out_valid_q;
    logic [IDX_W-1:0]   out_char_q;
    logic               out_done_q;
    logic               out_err_q;

    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    assign bus.out_done  = out_done_q;
    assign bus.out_err   = out_err_q;

    // Append the incoming bit and search the table; lowest matching index wins
    always_comb begin
        acc_nxt   = {acc[MAX_LEN-2:0], bus.bit_in};
        cnt_nxt   = cnt + LEN_W'(1);
        len_mask  = '0;
        for (int j = 0; j < MAX_LEN; j++) begin
            len_mask[j] = (LEN_W'(j) < cnt_nxt);
        end
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = SYM_NUM - 1; i >= 0; i--) begin
            if ((tbl_len[i] == cnt_nxt) && ((tbl_code[i] & len_mask) == acc_nxt)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    // Decide whether this cycle's bit is decoded and how the codeword ends
    always_comb begin
        take_bit = bus.bit_valid &&
                   (((state == READY) && !bus.in_valid) || (state == DECODE));
        overflow = !match_hit && (cnt_nxt == LEN_W'(MAX_LEN));
        word_end = match_hit || bus.bit_last || overflow;
        if (bus.bit_last) begin
            after_bit = READY;
        end else if (overflow) begin
            after_bit = DRAIN;
        end else begin
            after_bit = DECODE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; in_valid beats bit_valid in READY
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) state_nxt = LOAD;
            end
            LOAD: begin
                if (!bus.in_valid) begin
                    state_nxt = IDLE;
                end else if (load_idx == IDX_W'(SYM_NUM - 1)) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (bus.in_valid) begin
                    state_nxt = LOAD;
                end else if (take_bit) begin
                    state_nxt = after_bit;
                end
            end
            DECODE: begin
                if (take_bit) state_nxt = after_bit;
            end
            DRAIN: begin
                if (bus.bit_valid && bus.bit_last) state_nxt = READY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output pulses for the next cycle; out_char forced to 0 when not valid
    always_comb begin
        out_valid_d = take_bit && match_hit;
        out_char_d  = out_valid_d ? match_idx : '0;
        out_done_d  = take_bit && match_hit && bus.bit_last;
        out_err_d   = take_bit && !match_hit && (bus.bit_last || overflow);
    end

    // Table capture, bit accumulator and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYM_NUM; i++) begin
                tbl_len[i]  <= '0;
                tbl_code[i] <= '0;
            end
            load_idx    <= '0;
            acc         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            out_done_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            out_done_q  <= out_done_d;
            out_err_q   <= out_err_d;

            if (((state == IDLE) || (state == READY)) && bus.in_valid) begin
                tbl_len[0]  <= bus.in_len;
                tbl_code[0] <= bus.in_code;
                load_idx    <= IDX_W'(1);
            end else if (state == LOAD) begin
                if (bus.in_valid) begin
                    tbl_len[load_idx]  <= bus.in_len;
                    tbl_code[load_idx] <= bus.in_code;
                    load_idx           <= load_idx + IDX_W'(1);
                end else begin
                    for (int i = 0; i < SYM_NUM; i++) begin
                        tbl_len[i] <= '0;
                    end
                end
            end

            if (take_bit) begin
                if (word_end) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_huffman_dec.sv
// Self-checking bench for huffman_dec: directed scenarios plus random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_huffman_dec;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    huffman_dec_if bus();

    huffman_dec dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int t_len  [8] = '{4, 2, 3, 3, 5, 5, 3, 2};
    int t_code [8] = '{'b1110, 'b00, 'b100, 'b101, 'b11110, 'b11111, 'b110, 'b01};

    // Behavioural model: table, load progress, pending codeword as value+length
    int m_len  [8];
    int m_code [8];
    bit m_loading = 1'b0;
    bit m_have    = 1'b0;
    bit m_stream  = 1'b0;
    bit m_drain   = 1'b0;
    int m_idx     = 0;
    int m_plen    = 0;
    int m_pval    = 0;

    bit e_valid = 1'b0;
    int e_char  = 0;
    bit e_done  = 1'b0;
    bit e_err   = 1'b0;

    int obs_chars[$];
    int obs_done = 0;
    int obs_err  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_bit(input bit b, input bit last);
        int hit;
        m_pval = m_pval * 2 + int'(b);
        m_plen = m_plen + 1;
        hit = -1;
        for (int i = 7; i >= 0; i--) begin
            if (m_len[i] == m_plen && (m_code[i] % (1 << m_plen)) == m_pval) hit = i;
        end
        if (hit >= 0) begin
            e_valid = 1'b1;
            e_char  = hit;
            e_done  = last;
            m_plen  = 0;
            m_pval  = 0;
            if (last) m_stream = 1'b0;
        end else if (last || m_plen == 7) begin
            e_err    = 1'b1;
            m_drain  = !last;
            m_stream = 1'b0;
            m_plen   = 0;
            m_pval   = 0;
        end
    endtask

    // Reference model advances on each rising edge using the settled inputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_len[i] = 0;
            m_loading = 1'b0;
            m_have    = 1'b0;
            m_stream  = 1'b0;
            m_drain   = 1'b0;
            m_plen    = 0;
            m_pval    = 0;
            e_valid   = 1'b0;
            e_char    = 0;
            e_done    = 1'b0;
            e_err     = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_char  = 0;
            e_done  = 1'b0;
            e_err   = 1'b0;
            if (m_loading) begin
                if (bus.in_valid) begin
                    m_len[m_idx]  = int'(bus.in_len);
                    m_code[m_idx] = int'(bus.in_code);
                    m_idx++;
                    if (m_idx == 8) begin
                        m_loading = 1'b0;
                        m_have    = 1'b1;
                    end
                end else begin
                    for (int i = 0; i < 8; i++) m_len[i] = 0;
                    m_loading = 1'b0;
                    m_have    = 1'b0;
                end
            end else if (m_drain) begin
                if (bus.bit_valid && bus.bit_last) m_drain = 1'b0;
            end else if (m_stream) begin
                if (bus.bit_valid) model_bit(bus.bit_in, bus.bit_last);
            end else if (bus.in_valid) begin
                m_len[0]  = int'(bus.in_len);
                m_code[0] = int'(bus.in_code);
                m_idx     = 1;
                m_loading = 1'b1;
                m_have    = 1'b0;
            end else if (m_have && bus.bit_valid) begin
                m_stream = 1'b1;
                model_bit(bus.bit_in, bus.bit_last);
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        checkOutput("out_valid", int'(bus.out_valid), int'(e_valid));
        checkOutput("out_char",  int'(bus.out_char),  e_char);
        checkOutput("out_done",  int'(bus.out_done),  int'(e_done));
        checkOutput("out_err",   int'(bus.out_err),   int'(e_err));
        if (bus.out_valid) obs_chars.push_back(int'(bus.out_char));
        if (bus.out_done) obs_done++;
        if (bus.out_err) obs_err++;
    end

    function automatic int obs_at(input int i);
        return (i < obs_chars.size()) ? obs_chars[i] : -1;
    endfunction

    task automatic applyStimulus(input bit iv, input logic [2:0] len, input logic [6:0] code,
                                 input bit bv, input bit b, input bit bl);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_len    = len;
        bus.in_code   = code;
        bus.bit_valid = bv;
        bus.bit_in    = b;
        bus.bit_last  = bl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_table(input int lens[8], input int codes[8]);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 3'(lens[k]), 7'(codes[k]), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_code(input int len, input int code, input bit last);
        for (int j = len - 1; j >= 0; j--)
            applyStimulus(1'b0, 3'd0, 7'd0, 1'b1, bit'((code >> j) & 1), last && (j == 0));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_last  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_valid", int'(bus.out_valid), 0);
        checkOutput("reset_char",  int'(bus.out_char),  0);
        checkOutput("reset_done",  int'(bus.out_done),  0);
        checkOutput("reset_err",   int'(bus.out_err),   0);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_log();
        obs_chars.delete();
        obs_done = 0;
        obs_err  = 0;
    endtask

    initial begin
        int r_len [8];
        int r_code[8];
        int abort_at;

        bus.in_valid  = 1'b0;
        bus.in_len    = '0;
        bus.in_code   = '0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_last  = 1'b0;
        #12 rst_n = 1'b1;

        // Reset, then bits with no table are ignored
        pulse_reset();
        clear_log();
        applyStimulus(1'b0, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, 7'd0, 1'b1, 1'b1, 1'b0);
        idle(3);
        checkOutput("t1_no_chars", obs_chars.size(), 0);
        checkOutput("t1_no_err", obs_err, 0);

        // "BAL" back to back
        load_table(t_len, t_code);
        clear_log();
        send_code(2, 'b00, 1'b0);
        send_code(4, 'b1110, 1'b0);
        send_code(5, 'b11111, 1'b1);
        idle(3);
        checkOutput("t2_count", obs_chars.size(), 3);
        checkOutput("t2_char0", obs_at(0), 1);
        checkOutput("t2_char1", obs_at(1), 0);
        checkOutput("t2_char2", obs_at(2), 5);
        checkOutput("t2_done", obs_done, 1);

        // V then E with a 3-cycle stall
        load_table(t_len, t_code);
        clear_log();
        send_code(2, 'b01, 1'b0);
        idle(3);
        send_code(3, 'b101, 1'b1);
        idle(3);
        checkOutput("t3_count", obs_chars.size(), 2);
        checkOutput("t3_char0", obs_at(0), 7);
        checkOutput("t3_char1", obs_at(1), 3);
        checkOutput("t3_done", obs_done, 1);

        // Truncated codeword, then recovery
        load_table(t_len, t_code);
        clear_log();
        send_code(2, 'b11, 1'b1);
        idle(2);
        checkOutput("t4_err", obs_err, 1);
        checkOutput("t4_no_char", obs_chars.size(), 0);
        send_code(2, 'b00, 1'b1);
        idle(3);
        checkOutput("t4_char", obs_at(0), 1);
        checkOutput("t4_done", obs_done, 1);

        // Overflow with drain, then recovery
        for (int k = 0; k < 8; k++) begin
            r_len[k]  = 7;
            r_code[k] = k;
        end
        load_table(r_len, r_code);
        clear_log();
        send_code(7, 'b1111111, 1'b0);
        send_code(1, 0, 1'b1);
        idle(2);
        checkOutput("t5_err", obs_err, 1);
        checkOutput("t5_no_done", obs_done, 0);
        send_code(7, 'b0000011, 1'b1);
        idle(3);
        checkOutput("t5_char", obs_at(0), 3);
        checkOutput("t5_done", obs_done, 1);

        // Reset mid-codeword loses the table
        load_table(t_len, t_code);
        clear_log();
        send_code(2, 'b11, 1'b0);
        pulse_reset();
        send_code(3, 'b110, 1'b1);
        idle(2);
        checkOutput("t6_lost", obs_chars.size(), 0);
        load_table(t_len, t_code);
        send_code(3, 'b110, 1'b1);
        idle(3);
        checkOutput("t6_char", obs_at(0), 6);
        checkOutput("t6_done", obs_done, 1);

        // Random tables (some not prefix-free, some aborted) and random bits
        for (int r = 0; r < 40; r++) begin
            if (r % 10 == 7) pulse_reset();
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    r_len[k]  = t_len[k];
                    r_code[k] = t_code[k];
                end else begin
                    r_len[k]  = $urandom_range(0, 4);
                    r_code[k] = $urandom_range(0, 127);
                end
            end
            abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
            for (int k = 0; k < abort_at; k++)
                applyStimulus(1'b1, 3'(r_len[k]), 7'(r_code[k]), 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 40; c++)
                applyStimulus($urandom_range(0, 63) == 0, 3'($urandom_range(0, 7)),
                              7'($urandom_range(0, 127)), $urandom_range(0, 3) != 0,
                              1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0);
            applyStimulus(1'b0, 3'd0, 7'd0, 1'b1, 1'b0, 1'b1);
            idle(2);
        end

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
